// File: rtl/gcd_param.sv
// Iterative GCD engine: captures two unsigned operands on start and iterates one
// step per clock, using subtractive Euclid (MODE=0) or binary Stein (MODE=1).
module gcd_param #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ret,
  output logic [CNT_W-1:0] steps
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, ret_q, ret_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             accept, term;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign term   = (x_q == '0) || (y_q == '0) || (x_q == y_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The unused 2'b11 encoding falls into default and recovers to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (term)  state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE) || (state_q == DONE);
    done  = (state_q == DONE);
    ret   = ret_q;
    steps = steps_q;
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    ret_d   = ret_q;
    steps_d = steps_q;
    if (accept) begin
      x_d     = a;
      y_d     = b;
      k_d     = '0;
      steps_d = '0;
    end else if (state_q == RUN) begin
      if (term) begin
        ret_d = ((x_q == '0) ? y_q : x_q) << k_q;
      end else begin
        if (MODE == 0) begin
          if (x_q > y_q) x_d = x_q - y_q;
          else           y_d = y_q - x_q;
        end else begin
          case ({x_q[0], y_q[0]})
            2'b00: begin
              x_d = x_q >> 1;
              y_d = y_q >> 1;
              k_d = k_q + KW'(1);
            end
            2'b01:   x_d = x_q >> 1;
            2'b10:   y_d = y_q >> 1;
            default: begin
              if (x_q > y_q) x_d = x_q - y_q;
              else           y_d = y_q - x_q;
            end
          endcase
        end
        if (steps_q != '1) steps_d = steps_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      ret_q   <= '0;
      steps_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      ret_q   <= ret_d;
      steps_q <= steps_d;
    end
  end

endmodule

// File: tb/tb_gcd_param.sv
// Bench for gcd_param: directed cases on 8-bit Euclid/Stein instances and a random
// 16-bit Stein sweep checked against a modulo-based GCD reference.
module tb_gcd_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start0, start1, start2;
  logic [7:0] a0, b0, a1, b1;
  logic [15:0] a2, b2;
  logic       ready0, ready1, ready2, done0, done1, done2;
  logic [7:0] ret0, ret1;
  logic [15:0] ret2, steps0, steps1, steps2;

  gcd_param #(.WIDTH(8), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .ready(ready0), .done(done0), .ret(ret0), .steps(steps0));
  gcd_param #(.WIDTH(8), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .done(done1), .ret(ret1), .steps(steps1));
  gcd_param #(.WIDTH(16), .MODE(1), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .ret(ret2), .steps(steps2));

  int          sel;
  logic        s_ready, s_done;
  logic [15:0] s_ret, s_steps;

  always_comb begin
    s_ready = ready0; s_done = done0; s_ret = {8'h00, ret0}; s_steps = steps0;
    case (sel)
      1: begin s_ready = ready1; s_done = done1; s_ret = {8'h00, ret1}; s_steps = steps1; end
      2: begin s_ready = ready2; s_done = done2; s_ret = ret2; s_steps = steps2; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] last_ret [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic [15:0] aa, input logic [15:0] bb);
    case (which)
      0: begin start0 = s; a0 = aa[7:0]; b0 = bb[7:0]; end
      1: begin start1 = s; a1 = aa[7:0]; b1 = bb[7:0]; end
      default: begin start2 = s; a2 = aa; b2 = bb; end
    endcase
  endtask

  function automatic logic [15:0] ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[15:0];
  endfunction

  // Issue one request (taken from IDLE or DONE) and wait for done, bounded.
  task automatic run_op(input int which, input logic [15:0] aa, input logic [15:0] bb,
                        input int pulse_at, output logic [15:0] r, output logic [15:0] s,
                        output int lat);
    int n;
    sel = which;
    #0;
    chk("ready_before_start", {31'd0, s_ready}, 32'd1);
    drive(which, 1'b1, aa, bb);
    @(posedge clk);
    #1;
    drive(which, 1'b0, 16'($urandom), 16'($urandom));
    chk("ready_after_accept", {31'd0, s_ready}, 32'd0);
    chk("done_after_accept", {31'd0, s_done}, 32'd0);
    chk("ret_held_after_accept", {16'd0, s_ret}, {16'd0, last_ret[which]});
    n = 0;
    while (!s_done && n < 4000) begin
      @(posedge clk);
      n++;
      #1;
      if (pulse_at != 0 && n == pulse_at) drive(which, 1'b1, 16'd3, 16'd3);
      else drive(which, 1'b0, 16'($urandom), 16'($urandom));
    end
    if (!s_done) chk("done_timeout", 32'd0, 32'd1);
    r = s_ret;
    s = s_steps;
    lat = n;
  endtask

  logic [15:0] r, s, e;
  int lat;
  int unsigned ra, rb;
  logic [15:0] pa [4] = '{16'd0, 16'd9, 16'd0, 16'd255};
  logic [15:0] pb [4] = '{16'd7, 16'd0, 16'd0, 16'd255};
  logic [15:0] pr [4] = '{16'd7, 16'd9, 16'd0, 16'd255};

  initial begin
    sel = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 16'd0, 16'd0);
    drive(1, 1'b0, 16'd0, 16'd0);
    drive(2, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) last_ret[i] = 16'd0;
    #2;
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_ret", {24'd0, ret0}, 32'd0);
    chk("rst_steps", {16'd0, steps0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1 / T2: 48,18 on both 8-bit engines
    run_op(0, 16'd48, 16'd18, 0, r, s, lat);
    chk("t1_ret", {16'd0, r}, 32'd6);
    chk("t1_steps", {16'd0, s}, 32'd4);
    chk("t1_latency", lat, 32'd5);
    last_ret[0] = 16'd6;
    run_op(1, 16'd48, 16'd18, 0, r, s, lat);
    chk("t2_ret", {16'd0, r}, 32'd6);
    chk("t2_steps", {16'd0, s}, 32'd6);
    chk("t2_latency", lat, 32'd7);
    last_ret[1] = 16'd6;

    // T3: zero operands and equal operands terminate immediately
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        run_op(m, pa[i], pb[i], 0, r, s, lat);
        chk("t3_ret", {16'd0, r}, {16'd0, pr[i]});
        chk("t3_steps", {16'd0, s}, 32'd0);
        chk("t3_latency", lat, 32'd1);
        chk("t3_done", {31'd0, s_done}, 32'd1);
        last_ret[m] = pr[i];
      end
    end

    // T4: longest Euclid run, with a start pulse while busy
    run_op(0, 16'd1, 16'd255, 10, r, s, lat);
    chk("t4_ret", {16'd0, r}, 32'd1);
    chk("t4_steps", {16'd0, s}, 32'd254);
    chk("t4_latency", lat, 32'd255);
    last_ret[0] = 16'd1;

    // T5: asynchronous reset in the middle of a run
    sel = 0;
    drive(0, 1'b1, 16'd200, 16'd15);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {31'd0, ready0}, 32'd1);
    chk("t5_rst_done", {31'd0, done0}, 32'd0);
    chk("t5_rst_ret", {24'd0, ret0}, 32'd0);
    chk("t5_rst_steps", {16'd0, steps0}, 32'd0);
    for (int i = 0; i < 3; i++) last_ret[i] = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(0, 16'd200, 16'd15, 0, r, s, lat);
    chk("t5_ret", {16'd0, r}, 32'd5);
    chk("t5_latency", lat, {16'd0, s} + 32'd1);
    last_ret[0] = 16'd5;

    // T6: random 16-bit Stein sweep, each request accepted straight from DONE
    for (int i = 0; i < 1000; i++) begin
      ra = (i % 8 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 65535);
      rb = (i % 8 == 1) ? $urandom_range(0, 40) : $urandom_range(0, 65535);
      if (i % 16 == 2) rb = ra * $urandom_range(1, 3) % 65536;
      e = ref_gcd(ra, rb);
      run_op(2, ra[15:0], rb[15:0], 0, r, s, lat);
      chk("t6_ret", {16'd0, r}, {16'd0, e});
      chk("t6_latency", lat, {16'd0, s} + 32'd1);
      last_ret[2] = e;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
